// File: rtl/systolic_sched.sv
// Tile scheduler: sweeps col weight columns per tile into the array, fires conv_ctrl, waits conv_finish.
// Latency: first read 1 cycle after start, conv_ctrl at col+2, done 2 cycles after the last conv_finish.
// Backpressure: none; start is ignored while busy. Optional RUN watchdog under `define SCHED_TIMEOUT_EN.
module systolic_sched #(
  parameter int col     = 32,
  parameter int row     = 32,
  parameter int ADDR_W  = 10,
  parameter int TILE_W  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  output logic              busy,
  output logic              done,
  output logic [TILE_W-1:0] tile_idx,
  output logic              wbuf_rd_en,
  output logic [ADDR_W-1:0] wbuf_rd_addr,
  output logic [col-1:0]    weight_en,
  output logic              conv_ctrl,
  input  logic              conv_finish,
  output logic              err
);

  localparam int CW = (col > 1) ? $clog2(col) : 1;

  if (col < 2 || row < 1 || TIMEOUT < 1) begin : g_cfg_check
    $error("systolic_sched: unsupported configuration");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FLUSH, S_START, S_RUN, S_DONE
  } state_t;

  state_t            state;
  logic [CW-1:0]     col_cnt;
  logic [TILE_W-1:0] num_q;

`ifdef SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= S_IDLE;
      col_cnt      <= '0;
      num_q        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      tile_idx     <= '0;
      wbuf_rd_en   <= 1'b0;
      wbuf_rd_addr <= '0;
      weight_en    <= '0;
      conv_ctrl    <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      wd           <= '0;
      err          <= 1'b0;
`endif
    end else begin
      weight_en <= '0;
      conv_ctrl <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            num_q        <= num_tiles;
            tile_idx     <= '0;
            busy         <= 1'b1;
            col_cnt      <= '0;
            wbuf_rd_addr <= '0;
`ifdef SCHED_TIMEOUT_EN
            err          <= 1'b0;
`endif
            if (num_tiles == '0) begin
              state <= S_DONE;
            end else begin
              state      <= S_LOAD;
              wbuf_rd_en <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          // The column enable trails the read by one cycle to line up with buffer data.
          weight_en <= {{(col-1){1'b0}}, 1'b1} << col_cnt;
          if (col_cnt == CW'(col - 1)) begin
            wbuf_rd_en <= 1'b0;
            col_cnt    <= '0;
            state      <= S_FLUSH;
          end else begin
            col_cnt      <= col_cnt + 1'b1;
            wbuf_rd_addr <= wbuf_rd_addr + 1'b1;
          end
        end
        S_FLUSH: begin
          conv_ctrl <= 1'b1;
          state     <= S_START;
        end
        S_START: begin
          state <= S_RUN;
`ifdef SCHED_TIMEOUT_EN
          wd    <= '0;
`endif
        end
        S_RUN: begin
          if (conv_finish) begin
            if (tile_idx == num_q - 1'b1) begin
              state <= S_DONE;
            end else begin
              // Tiles are contiguous, so the running address already equals tile_idx*col+c.
              tile_idx     <= tile_idx + 1'b1;
              wbuf_rd_addr <= wbuf_rd_addr + 1'b1;
              wbuf_rd_en   <= 1'b1;
              state        <= S_LOAD;
            end
          end
`ifdef SCHED_TIMEOUT_EN
          else if (wd == WD_W'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            wd <= wd + 1'b1;
          end
`endif
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_sched.sv
// Directed bench for systolic_sched with col=4, ADDR_W=4 (so address wrap is reachable), TIMEOUT=16.
module tb_systolic_sched;

  localparam int COLS = 4;
  localparam int AW   = 4;
  localparam int TW   = 8;

  logic          clk = 1'b0;
  logic          nrst;
  logic          start;
  logic [TW-1:0] num_tiles;
  logic          busy, done, wbuf_rd_en, conv_ctrl, conv_finish, err;
  logic [TW-1:0] tile_idx;
  logic [AW-1:0] wbuf_rd_addr;
  logic [COLS-1:0] weight_en;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  systolic_sched #(.col(COLS), .row(4), .ADDR_W(AW), .TILE_W(TW), .TIMEOUT(16)) dut (
    .clk(clk), .nrst(nrst), .start(start), .num_tiles(num_tiles),
    .busy(busy), .done(done), .tile_idx(tile_idx),
    .wbuf_rd_en(wbuf_rd_en), .wbuf_rd_addr(wbuf_rd_addr), .weight_en(weight_en),
    .conv_ctrl(conv_ctrl), .conv_finish(conv_finish), .err(err)
  );

  task automatic chk(input string tag, input int t, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s @t%0d observed=%0h expected=%0h", tag, t, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " rd_en"}, 0, 32'(wbuf_rd_en), 0);
    chk({tag, " rd_addr"}, 0, 32'(wbuf_rd_addr), 0);
    chk({tag, " weight_en"}, 0, 32'(weight_en), 0);
    chk({tag, " conv_ctrl"}, 0, 32'(conv_ctrl), 0);
    chk({tag, " busy"}, 0, 32'(busy), 0);
    chk({tag, " done"}, 0, 32'(done), 0);
    chk({tag, " tile_idx"}, 0, 32'(tile_idx), 0);
    chk({tag, " err"}, 0, 32'(err), 0);
  endtask

  // Runs one layer of n tiles, conv_finish fd cycles after each conv_ctrl. Cycle 0 is the start cycle.
  // noise adds stray start/conv_finish pulses; stop>0 returns right after checking that cycle.
  task automatic run_layer(input int n, input int fd, input bit noise, input int stop);
    int p, last, k, ph, cc_cnt, dn_cnt;
    bit act;
    p = 6 + fd;
    last = n * p + 2;
    cc_cnt = 0;
    dn_cnt = 0;
    start = 1'b1;
    num_tiles = TW'(n);
    for (int t = 1; t <= last; t++) begin
      tick();
      k = (t - 1) / p;
      ph = (t - 1) % p;
      act = (k < n);
      start = noise && (t == 2 || t == 10);
      num_tiles = noise ? TW'(5) : TW'(n);
      conv_finish = (act && ph == p - 1) || (noise && (t == 3 || t == 6));
      if (conv_ctrl) cc_cnt++;
      if (done) dn_cnt++;
      chk("rd_en", t, 32'(wbuf_rd_en), 32'(act && ph < COLS));
      if (act && ph < COLS) chk("rd_addr", t, 32'(wbuf_rd_addr), (k * COLS + ph) % (1 << AW));
      chk("weight_en", t, 32'(weight_en), (act && ph >= 1 && ph <= COLS) ? (1 << (ph - 1)) : 0);
      chk("conv_ctrl", t, 32'(conv_ctrl), 32'(act && ph == 5));
      chk("busy", t, 32'(busy), 32'(t <= n * p + 1));
      chk("done", t, 32'(done), 32'(t == last));
      chk("tile_idx", t, 32'(tile_idx), act ? k : n - 1);
      chk("err", t, 32'(err), 0);
      if (t == stop) return;
    end
    conv_finish = 1'b0;
    start = 1'b0;
    chk("conv_ctrl_count", last, cc_cnt, n);
    chk("done_count", last, dn_cnt, 1);
  endtask

  initial begin
    int dcount, dfirst;
    nrst = 1'b0;
    start = 1'b0;
    num_tiles = '0;
    conv_finish = 1'b0;
    #12;
    chk_idle_zero("reset");
    nrst = 1'b1;
    tick();

    // One tile: conv_finish at cycle 20, done at 22.
    run_layer(1, 14, 1'b0, 0);

    // Three tiles, conv_finish 10 cycles after each conv_ctrl; tile_idx holds afterwards.
    run_layer(3, 10, 1'b0, 0);
    tick();
    tick();
    chk("tile_idx_hold", 0, 32'(tile_idx), 2);
    chk("busy_idle", 0, 32'(busy), 0);

    // Five tiles push the 4-bit address past 15 so it wraps.
    run_layer(5, 2, 1'b0, 0);

    // Zero tiles: a single done, no load/conv activity.
    start = 1'b1;
    num_tiles = '0;
    dcount = 0;
    dfirst = 0;
    for (int t = 1; t <= 4; t++) begin
      tick();
      start = 1'b0;
      if (done) begin
        dcount++;
        if (dfirst == 0) dfirst = t;
      end
      chk("zero rd_en", t, 32'(wbuf_rd_en), 0);
      chk("zero weight_en", t, 32'(weight_en), 0);
      chk("zero conv_ctrl", t, 32'(conv_ctrl), 0);
    end
    chk("zero done_count", 0, dcount, 1);
    chk("zero done_by_t2", 0, 32'(dfirst >= 1 && dfirst <= 2), 1);
    chk("zero busy_after", 4, 32'(busy), 0);

    // Stray start / conv_finish pulses must not disturb the one-tile sequence.
    run_layer(1, 14, 1'b1, 0);

    // Reset in the middle of tile 1 LOAD, then a clean restart.
    run_layer(2, 3, 1'b0, 12);
    nrst = 1'b0;
    #1;
    chk_idle_zero("midreset");
    #3;
    nrst = 1'b1;
    tick();
    run_layer(1, 14, 1'b0, 0);

`ifdef SCHED_TIMEOUT_EN
    // No conv_finish: watchdog fires 16 cycles into RUN (RUN starts at cycle 7).
    start = 1'b1;
    num_tiles = TW'(1);
    for (int t = 1; t <= 24; t++) begin
      tick();
      start = 1'b0;
      if (t == 22) begin
        chk("wd busy", t, 32'(busy), 1);
        chk("wd err", t, 32'(err), 0);
        chk("wd done", t, 32'(done), 0);
      end
      if (t == 23) begin
        chk("wd busy", t, 32'(busy), 0);
        chk("wd err", t, 32'(err), 1);
        chk("wd done", t, 32'(done), 1);
      end
      if (t == 24) begin
        chk("wd done", t, 32'(done), 0);
        chk("wd err_sticky", t, 32'(err), 1);
      end
    end
    start = 1'b1;
    num_tiles = '0;
    tick();
    start = 1'b0;
    chk("wd err_cleared", 1, 32'(err), 0);
    tick();
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
